cv32e40x_hazard_scoreboard: RTL
===============================

CV32E40X_HAZARD_SCOREBOARD -- requirements
Module: cv32e40x_hazard_scoreboard

Interface
REQ-001 SHALL have parameter REGFILE_NUM_READ_PORTS, default 2, number of ID read ports checked.
REQ-002 SHALL have parameter MAX_PENDING, default 3, range 1..7, the maximum number of in-flight writes tracked per register.
REQ-003 SHALL have parameter NUM_REGS, default 32, the number of architectural registers; register x0 is never tracked.
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port issue_valid_i, input, 1: an instruction leaves ID toward EX this cycle (ID valid and EX ready).
REQ-007 SHALL have port issue_we_i, input, 1: the issued instruction writes the register file.
REQ-008 SHALL have port issue_waddr_i, input, $clog2(NUM_REGS): destination of the issued instruction.
REQ-009 SHALL have port issue_late_i, input, 1: the result is available only in WB (load, mul/div, CSR counter read).
REQ-010 SHALL have port rf_re_id_i, input, REGFILE_NUM_READ_PORTS: per-port read enable in ID.
REQ-011 SHALL have port rf_raddr_id_i, input, REGFILE_NUM_READ_PORTS x $clog2(NUM_REGS): per-port read address in ID.
REQ-012 SHALL have port retire_valid_i, input, 1: a register-file write commits in WB this cycle.
REQ-013 SHALL have port retire_waddr_i, input, $clog2(NUM_REGS): the committed write address.
REQ-014 SHALL have port flush_i, input, 1: EX and WB are killed (trap, debug entry, or fence.i).
REQ-015 SHALL have port hazard_o, output, REGFILE_NUM_READ_PORTS: per-port RAW hazard.
REQ-016 SHALL have port stall_id_o, output, 1: ID must not issue.
REQ-017 SHALL have port pending_cnt_o, output, $clog2(NUM_REGS*MAX_PENDING+1): total in-flight tracked writes.
REQ-018 SHALL have port underflow_o, output, 1: one-cycle pulse on a retire to a register whose count is 0.

Function
REQ-019 SHALL keep a count cnt[r] in 0..MAX_PENDING and a late flag late[r] for each register r from 1 to NUM_REGS-1.
REQ-020 SHALL increment cnt[r] on a cycle with issue_valid_i & issue_we_i & waddr==r (r!=0), and SHALL set late[r]=issue_late_i on that cycle.
REQ-021 SHALL decrement cnt[r] on a cycle with retire_valid_i & retire_waddr_i==r & cnt[r]>0, and SHALL clear late[r] when cnt[r] reaches 0.
REQ-022 SHALL leave cnt[r] unchanged when an issue and a retire to the same r occur in the same cycle, while late[r] takes issue_late_i.
REQ-023 SHALL leave the count unchanged on a retire with cnt[r]==0 and pulse underflow_o for one cycle.
REQ-024 SHALL, on flush_i, set every cnt to 0 and every late flag to 0 on the next edge; flush takes priority over a same-cycle issue or retire.
REQ-025 SHALL compute hazard_o[p] combinationally as rf_re_id_i[p] & raddr!=0 & cnt[raddr]>0, gated per REQ-030.
REQ-026 SHALL drive stall_id_o = |hazard_o | (issue_we_i & cnt[issue_waddr_i]==MAX_PENDING), with a saturated count blocking a further issue.
REQ-027 SHALL assert stall_id_o with zero latency, so an issue_valid_i in the same cycle as stall_id_o is a protocol violation and is ignored for counting.
REQ-028 SHALL register pending_cnt_o as the sum of all counts, one cycle after the update.

Reset
REQ-029 SHALL on rst_n low asynchronously clear all counts and late flags, and SHALL drive hazard_o=0, stall_id_o=0, pending_cnt_o=0, underflow_o=0 while in reset.

Configuration
REQ-030 SHALL honour macro CV32E40X_SCOREBOARD_BYPASS_EN: when defined, a hazard is raised only if late[raddr]=1 (EX/WB forwarding covers non-late results); when undefined, any cnt>0 raises a hazard (no forwarding).

Verification
REQ-031 SHALL pass: issue late write x5, next cycle read x5 on port 0 -> hazard_o=01, stall_id_o=1 until the retire of x5, then 0 the following cycle.
REQ-032 SHALL pass: with BYPASS_EN defined, issue non-late write x7 and read x7 -> hazard_o=0; with it undefined -> hazard_o=01.
REQ-033 SHALL pass: issue to x3 three times with MAX_PENDING=3, then a fourth attempt -> stall_id_o=1 and cnt[x3] stays 3.
REQ-034 SHALL pass: issue x9 and retire x9 in the same cycle with cnt=1 -> cnt remains 1 and pending_cnt_o is unchanged.
REQ-035 SHALL pass: flush_i with 4 pending writes -> pending_cnt_o=0 two cycles later and no hazards; a retire to x4 afterwards -> underflow_o pulses once.
REQ-036 SHALL pass: a read of x0 on both ports with pending issues to x0 -> hazard_o=00 and pending_cnt_o=0.

Source files
------------

// File: rtl/cv32e40x_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// cv32e40x_hazard_scoreboard
//
// Tracks in-flight register-file writes between ID issue and WB commit and
// raises read-after-write hazards for the ID read ports.
//
// Every architectural register r (1..NUM_REGS-1) has a saturating count of
// outstanding writes plus a "late" flag. The flag marks a result that only
// appears in WB (load, mul/div, CSR counter read). Register x0 is never
// tracked. A flush clears all tracking state.
//
// Optional feature macro: CV32E40X_SCOREBOARD_BYPASS_EN
//   defined   : EX/WB forwarding is assumed. Only a late pending write causes
//               a hazard.
//   undefined : any pending write to a read register causes a hazard.
//
// Parameters
//   REGFILE_NUM_READ_PORTS : number of ID read ports checked (default 2)
//   MAX_PENDING            : in-flight writes tracked per register (1..7)
//   NUM_REGS               : architectural registers (default 32)
//
// Ports
//   clk, rst_n      : clock, asynchronous active-low reset
//   issue_valid_i   : instruction leaves ID toward EX this cycle
//   issue_we_i      : issued instruction writes the register file
//   issue_waddr_i   : destination register of the issued instruction
//   issue_late_i    : result of the issued instruction is only ready in WB
//   rf_re_id_i      : per-port read enable in ID
//   rf_raddr_id_i   : per-port read address in ID
//   retire_valid_i  : register-file write commits in WB this cycle
//   retire_waddr_i  : address of the committed write
//   flush_i         : EX and WB are killed
//   hazard_o        : per-port RAW hazard (combinational)
//   stall_id_o      : ID must not issue (combinational)
//   pending_cnt_o   : registered total of in-flight tracked writes
//   underflow_o     : registered one-cycle pulse on a retire to a zero count
// -----------------------------------------------------------------------------
module cv32e40x_hazard_scoreboard #(
   parameter int unsigned REGFILE_NUM_READ_PORTS = 2,
   parameter int unsigned MAX_PENDING            = 3,
   parameter int unsigned NUM_REGS               = 32
) (
   input  logic                                                     clk,
   input  logic                                                     rst_n,
   input  logic                                                     issue_valid_i,
   input  logic                                                     issue_we_i,
   input  logic [$clog2(NUM_REGS)-1:0]                              issue_waddr_i,
   input  logic                                                     issue_late_i,
   input  logic [REGFILE_NUM_READ_PORTS-1:0]                        rf_re_id_i,
   input  logic [REGFILE_NUM_READ_PORTS-1:0][$clog2(NUM_REGS)-1:0]  rf_raddr_id_i,
   input  logic                                                     retire_valid_i,
   input  logic [$clog2(NUM_REGS)-1:0]                              retire_waddr_i,
   input  logic                                                     flush_i,
   output logic [REGFILE_NUM_READ_PORTS-1:0]                        hazard_o,
   output logic                                                     stall_id_o,
   output logic [$clog2(NUM_REGS*MAX_PENDING+1)-1:0]                pending_cnt_o,
   output logic                                                     underflow_o
);

   localparam int unsigned AW = $clog2(NUM_REGS);
   localparam int unsigned CW = $clog2(MAX_PENDING + 1);
   localparam int unsigned PW = $clog2(NUM_REGS * MAX_PENDING + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PENDING);

   logic [CW-1:0]       r_cnt      [NUM_REGS];
   logic [NUM_REGS-1:0] r_late;
   logic [PW-1:0]       r_pending;
   logic                r_underflow;

   logic [CW-1:0]       w_cnt_nxt  [NUM_REGS];
   logic [NUM_REGS-1:0] w_late_nxt;
   logic [PW-1:0]       w_sum;
   logic                w_issue;
   logic                w_retire;
   logic                w_underflow;
   logic                w_sat_stall;

   // An issue is counted only when ID is not stalled. A saturated
   // destination or any read hazard blocks it in the same cycle.
   // x0 is excluded here, so entry 0 never leaves its reset value.
   assign w_issue  = issue_valid_i & issue_we_i & ~stall_id_o & (issue_waddr_i != '0);
   assign w_retire = retire_valid_i & (retire_waddr_i != '0);

   // -------------------------------------------------------------------------
   // Per-register next state. Flush wins over issue and retire.
   // -------------------------------------------------------------------------
   always_comb begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         logic w_iss_hit;
         logic w_ret_hit;
         w_iss_hit     = w_issue  && (issue_waddr_i  == AW'(i));
         w_ret_hit     = w_retire && (retire_waddr_i == AW'(i));
         w_cnt_nxt[i]  = r_cnt[i];
         w_late_nxt[i] = r_late[i];
         if (flush_i) begin
            w_cnt_nxt[i]  = '0;
            w_late_nxt[i] = 1'b0;
         end else if (w_iss_hit && w_ret_hit) begin
            // One write leaves and one enters, so the count is unchanged.
            // A retire that finds a zero count is an underflow and removes
            // nothing, so only the issue counts.
            if (r_cnt[i] == '0) begin
               w_cnt_nxt[i] = CW'(1);
            end
            w_late_nxt[i] = issue_late_i;
         end else if (w_iss_hit) begin
            w_cnt_nxt[i]  = r_cnt[i] + CW'(1);
            w_late_nxt[i] = issue_late_i;
         end else if (w_ret_hit && (r_cnt[i] != '0)) begin
            w_cnt_nxt[i] = r_cnt[i] - CW'(1);
            if (r_cnt[i] == CW'(1)) begin
               w_late_nxt[i] = 1'b0;
            end
         end
      end
   end

   // -------------------------------------------------------------------------
   // Hazard and stall detection
   // -------------------------------------------------------------------------
   always_comb begin
      hazard_o = '0;
      for (int unsigned p = 0; p < REGFILE_NUM_READ_PORTS; p++) begin
`ifdef CV32E40X_SCOREBOARD_BYPASS_EN
         hazard_o[p] = rf_re_id_i[p] && (rf_raddr_id_i[p] != '0) &&
                       (r_cnt[rf_raddr_id_i[p]] != '0) && r_late[rf_raddr_id_i[p]];
`else
         hazard_o[p] = rf_re_id_i[p] && (rf_raddr_id_i[p] != '0) &&
                       (r_cnt[rf_raddr_id_i[p]] != '0);
`endif
      end
   end

   assign w_sat_stall = issue_we_i & (r_cnt[issue_waddr_i] == CNT_MAX);
   // All counts are zero during reset, so hazard and stall are already low.
   assign stall_id_o  = (|hazard_o) | w_sat_stall;

   // -------------------------------------------------------------------------
   // Pending total and underflow detection
   // -------------------------------------------------------------------------
   always_comb begin
      w_sum = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         w_sum = w_sum + PW'(r_cnt[i]);
      end
   end

   assign w_underflow = w_retire & ~flush_i & (r_cnt[retire_waddr_i] == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            r_cnt[i] <= '0;
         end
         r_late      <= '0;
         r_pending   <= '0;
         r_underflow <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            r_cnt[i] <= w_cnt_nxt[i];
         end
         r_late      <= w_late_nxt;
         r_pending   <= w_sum;
         r_underflow <= w_underflow;
      end
   end

   assign pending_cnt_o = r_pending;
   assign underflow_o   = r_underflow;

endmodule
